// File: rtl/imem_loader.sv
// Instruction-memory writer: packs a byte stream MSB-first into 32-bit words,
// writes them to consecutive IMem addresses from 0, and holds the CPU until a clean load ends.
module imem_loader #(
  parameter int size      = 32,
  parameter int MemSize   = 512,
  parameter int AddrWidth = 9
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 load_start,
  input  logic                 load_end,
  input  logic                 in_valid,
  input  logic [7:0]           in_data,
  output logic                 in_ready,
  output logic                 imem_wea,
  output logic [AddrWidth-1:0] imem_addra,
  output logic [size-1:0]      imem_dina,
  output logic                 cpu_hold,
  output logic                 load_done,
  output logic                 load_err,
  output logic [AddrWidth:0]   word_count
);

  typedef enum logic [2:0] {IDLE, LOAD, WRITE, DONE, ERR} state_t;

  localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(MemSize - 1);
  localparam logic [AddrWidth-1:0] AddrOne  = AddrWidth'(1);
  localparam logic [AddrWidth:0]   WcOne    = (AddrWidth + 1)'(1);

  state_t                 state_q, state_d;
  logic [1:0]             byte_cnt_q, byte_cnt_d;
  logic [size-1:0]        word_q, word_d;
  logic [AddrWidth-1:0]   addr_q, addr_d;
  logic [AddrWidth:0]     wc_q, wc_d;
  logic                   end_pend_q, end_pend_d;
  logic [AddrWidth-1:0]   addra_q, addra_d;
  logic [size-1:0]        dina_q, dina_d;
  logic                   hold_q, hold_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic                   accept;
  logic                   pend;
  logic [size-1:0]        shifted;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      byte_cnt_q <= '0;
      word_q     <= '0;
      addr_q     <= '0;
      wc_q       <= '0;
      end_pend_q <= 1'b0;
      addra_q    <= '0;
      dina_q     <= '0;
      hold_q     <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
      addr_q     <= addr_d;
      wc_q       <= wc_d;
      end_pend_q <= end_pend_d;
      addra_q    <= addra_d;
      dina_q     <= dina_d;
      hold_q     <= hold_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    addr_d     = addr_q;
    wc_d       = wc_q;
    end_pend_d = end_pend_q;
    addra_d    = addra_q;
    dina_d     = dina_q;
    in_ready   = (state_q == LOAD);
    imem_wea   = (state_q == WRITE);
    accept     = in_valid & in_ready;
    pend       = end_pend_q | load_end;
    shifted    = {word_q[size-9:0], in_data};

    unique case (state_q)
      LOAD: begin
        if (accept) begin
          word_d     = shifted;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            state_d    = WRITE;
            addra_d    = addr_q;
            dina_d     = shifted;
            end_pend_d = load_end;
          end else if (load_end) begin
            state_d = ERR;
          end
        end else if (load_end) begin
          state_d = (byte_cnt_q == 2'd0) ? DONE : ERR;
        end
      end
      WRITE: begin
        addr_d     = addr_q + AddrOne;
        wc_d       = wc_q + WcOne;
        byte_cnt_d = '0;
        end_pend_d = 1'b0;
        // The last IMem slot is only a clean finish if the host also ended there.
        if (addr_q == LastAddr) state_d = pend ? DONE : ERR;
        else                    state_d = pend ? DONE : LOAD;
      end
      default: ;
    endcase

    if (load_start) begin
      state_d    = LOAD;
      byte_cnt_d = '0;
      word_d     = '0;
      addr_d     = '0;
      wc_d       = '0;
      end_pend_d = 1'b0;
    end

    hold_d = (state_d != DONE);
    done_d = (state_d == DONE);
    err_d  = (state_d == ERR);
  end

  assign imem_addra = addra_q;
  assign imem_dina  = dina_q;
  assign cpu_hold   = hold_q;
  assign load_done  = done_q;
  assign load_err   = err_q;
  assign word_count = wc_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboarded bench for imem_loader: expected IMem writes are queued as bytes
// are driven and matched against every imem_wea pulse by a negedge monitor.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        load_start = 1'b0;
  logic        load_end = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready;
  logic        imem_wea;
  logic [8:0]  imem_addra;
  logic [31:0] imem_dina;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;
  logic [9:0]  word_count;

  typedef struct packed {logic [8:0] a; logic [31:0] d;} wr_t;
  wr_t exp_q[$];

  int tests = 0;
  int fails = 0;

  imem_loader #(.size(32), .MemSize(512), .AddrWidth(9)) dut (
    .clk(clk), .reset_n(reset_n), .load_start(load_start), .load_end(load_end),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .imem_wea(imem_wea), .imem_addra(imem_addra), .imem_dina(imem_dina),
    .cpu_hold(cpu_hold), .load_done(load_done), .load_err(load_err),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_wea === 1'b1) begin
      wr_t e;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write: got addr=%0d data=%h, required no write", imem_addra, imem_dina);
      end else begin
        e = exp_q.pop_front();
        if (imem_addra !== e.a || imem_dina !== e.d) begin
          fails++;
          $display("FAIL write: got addr=%0d data=%h, required addr=%0d data=%h",
                   imem_addra, imem_dina, e.a, e.d);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b, input bit rnd, input bit with_end);
    int n;
    if (rnd) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    load_end = with_end;
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    load_end = 1'b0;
    if (n >= 20) begin
      tests++;
      fails++;
      $display("FAIL byte_timeout: in_ready=%b, required 1 within 20 cycles", in_ready);
    end
  endtask

  task automatic send_word(input logic [8:0] a, input logic [31:0] w, input bit rnd, input bit with_end);
    send_byte(w[31:24], rnd, 1'b0);
    send_byte(w[23:16], rnd, 1'b0);
    send_byte(w[15:8],  rnd, 1'b0);
    exp_q.push_back({a, w});
    send_byte(w[7:0],   rnd, with_end);
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  task automatic pulse_end();
    load_end = 1'b1;
    @(negedge clk);
    load_end = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({in_ready, imem_wea, cpu_hold, load_done, load_err, word_count} !== {5'b00100, 10'd0}) begin
      fails++;
      $display("FAIL reset_outputs: got rdy=%b wea=%b hold=%b done=%b err=%b wc=%0d, required 0 0 1 0 0 0",
               in_ready, imem_wea, cpu_hold, load_done, load_err, word_count);
    end
    reset_n = 1'b1;
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b0 || cpu_hold !== 1'b1) begin
      fails++;
      $display("FAIL idle_after_reset: got rdy=%b hold=%b, required 0 1", in_ready, cpu_hold);
    end
  endtask

  task automatic test_single_word();
    pulse_start();
    send_word(9'd0, 32'h8C220005, 1'b0, 1'b0);
    tests++;
    if (imem_wea !== 1'b1 || cpu_hold !== 1'b1 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL write_latency: got wea=%b hold=%b rdy=%b, required 1 1 0", imem_wea, cpu_hold, in_ready);
    end
    @(negedge clk);
    pulse_end();
    tests++;
    if (load_done !== 1'b1 || cpu_hold !== 1'b0 || load_err !== 1'b0 || word_count !== 10'd1 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL single_done: got done=%b hold=%b err=%b wc=%0d rdy=%b, required 1 0 0 1 0",
               load_done, cpu_hold, load_err, word_count, in_ready);
    end
  endtask

  task automatic test_random_valid();
    logic [31:0] w [3];
    w[0] = 32'hDEADBEEF; w[1] = 32'h01234567; w[2] = 32'hA5C3_0F1E;
    pulse_start();
    tests++;
    if (load_done !== 1'b0 || cpu_hold !== 1'b1 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL restart_clears: got done=%b hold=%b rdy=%b, required 0 1 1", load_done, cpu_hold, in_ready);
    end
    for (int i = 0; i < 3; i++) send_word(9'(i), w[i], 1'b1, 1'b0);
    @(negedge clk);
    pulse_end();
    tests++;
    if (load_done !== 1'b1 || word_count !== 10'd3) begin
      fails++;
      $display("FAIL three_words: got done=%b wc=%0d, required 1 3", load_done, word_count);
    end
  endtask

  task automatic test_partial_end();
    pulse_start();
    send_word(9'd0, 32'h11223344, 1'b0, 1'b0);
    send_byte(8'h55, 1'b0, 1'b0);
    send_byte(8'h66, 1'b0, 1'b0);
    pulse_end();
    repeat (3) @(negedge clk);
    tests++;
    if (load_err !== 1'b1 || cpu_hold !== 1'b1 || load_done !== 1'b0 || word_count !== 10'd1 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL partial_err: got err=%b hold=%b done=%b wc=%0d rdy=%b, required 1 1 0 1 0",
               load_err, cpu_hold, load_done, word_count, in_ready);
    end
  endtask

  task automatic test_end_with_last_byte();
    pulse_start();
    send_word(9'd0, 32'hCAFEF00D, 1'b0, 1'b0);
    send_word(9'd1, 32'h0BADC0DE, 1'b0, 1'b1);
    tests++;
    if (imem_wea !== 1'b1 || load_done !== 1'b0) begin
      fails++;
      $display("FAIL end_pend_write: got wea=%b done=%b, required 1 0", imem_wea, load_done);
    end
    @(negedge clk);
    tests++;
    if (load_done !== 1'b1 || cpu_hold !== 1'b0 || word_count !== 10'd2) begin
      fails++;
      $display("FAIL end_pend_done: got done=%b hold=%b wc=%0d, required 1 0 2", load_done, cpu_hold, word_count);
    end
  endtask

  task automatic test_overflow();
    pulse_start();
    for (int i = 0; i < 512; i++) send_word(9'(i), $urandom, 1'b0, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'h77;
    repeat (3) @(negedge clk);
    tests++;
    if (load_err !== 1'b1 || load_done !== 1'b0 || in_ready !== 1'b0 || word_count !== 10'd512 || cpu_hold !== 1'b1) begin
      fails++;
      $display("FAIL overflow: got err=%b done=%b rdy=%b wc=%0d hold=%b, required 1 0 0 512 1",
               load_err, load_done, in_ready, word_count, cpu_hold);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_and_restart();
    pulse_start();
    send_byte(8'h12, 1'b0, 1'b0);
    send_byte(8'h34, 1'b0, 1'b0);
    #3 reset_n = 1'b0;
    #1;
    tests++;
    if ({in_ready, imem_wea, cpu_hold, load_done, load_err, word_count} !== {5'b00100, 10'd0}) begin
      fails++;
      $display("FAIL async_reset: got rdy=%b wea=%b hold=%b done=%b err=%b wc=%0d, required 0 0 1 0 0 0",
               in_ready, imem_wea, cpu_hold, load_done, load_err, word_count);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    pulse_start();
    send_byte(8'h99, 1'b0, 1'b0);
    pulse_end();
    tests++;
    if (load_err !== 1'b1) begin
      fails++;
      $display("FAIL err_before_restart: got err=%b, required 1", load_err);
    end
    pulse_start();
    tests++;
    if (load_err !== 1'b0 || load_done !== 1'b0 || cpu_hold !== 1'b1 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL err_cleared: got err=%b done=%b hold=%b rdy=%b, required 0 0 1 1",
               load_err, load_done, cpu_hold, in_ready);
    end
    send_word(9'd0, 32'h13579BDF, 1'b0, 1'b0);
    @(negedge clk);
    send_byte(8'hAB, 1'b0, 1'b0);
    // restart mid-word with a byte presented on the same cycle; that byte must be dropped
    in_valid = 1'b1;
    in_data  = 8'hEE;
    pulse_start();
    in_valid = 1'b0;
    send_word(9'd0, 32'h2468ACE0, 1'b0, 1'b0);
    @(negedge clk);
    pulse_end();
    tests++;
    if (load_done !== 1'b1 || word_count !== 10'd1 || load_err !== 1'b0) begin
      fails++;
      $display("FAIL restart_done: got done=%b wc=%0d err=%b, required 1 1 0", load_done, word_count, load_err);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_random_valid();
    test_partial_end();
    test_end_with_last_byte();
    test_overflow();
    test_reset_and_restart();
    repeat (3) @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL missing_writes: got %0d writes outstanding, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
